lsu_pipe: RTL and testbench

Parametrised, pipelined load/store unit that replaces the single-cycle LSU between the core's EX/MEM stages and the Avalon data bus. It registers each accepted memory request into a command stage, holds it on the bus under `dbus_waitrequest`, and tracks up to `MAX_OUTSTANDING` in-flight loads in a metadata queue. Returned read data is lane-extracted and sign/zero-extended for 32- or 64-bit data paths. Byte enables are computed from the current request's address, and misaligned accesses are trapped before issue.

---
 rtl/lsu_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pipe.sv
// lsu_pipe: pipelined load/store unit between the core and an Avalon data bus.
// A command stage holds one request on the bus until waitrequest drops. A
// small metadata queue tracks issued loads so returned data can be
// lane-extracted and extended in order.
// Optional feature macro: LSU_STORE_ALIGN_EN replicates store data across all
// byte lanes (registered with the command); otherwise store data passes
// through unmodified.
//
// Handshakes: a request transfers on a cycle where lsu_req_valid and
// lsu_req_ready are both high; a bus command transfers on a cycle where
// dbus_read/dbus_write is high and dbus_waitrequest is low; read data
// transfers on any cycle with dbus_readdatavalid high (in order).
module lsu_pipe #(
  parameter int DW              = 32,
  parameter int AW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_req_write,
  input  logic [2:0]      lsu_req_opcode,
  input  logic [AW-1:0]   lsu_req_address,
  input  logic [DW-1:0]   lsu_req_writedata,
  output logic            dbus_read,
  output logic            dbus_write,
  output logic [AW-1:0]   dbus_address,
  output logic [DW/8-1:0] dbus_byte_enable,
  output logic [DW-1:0]   dbus_writedata,
  input  logic            dbus_waitrequest,
  input  logic [DW-1:0]   dbus_readdata,
  input  logic            dbus_readdatavalid,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_resp_readdata,
  output logic            exception_load_addr_misaligned,
  output logic            exception_store_addr_misaligned,
  output logic            lsu_busy,
  output logic            dbg_state
);
  localparam int BW = DW / 8;
  localparam int OB = $clog2(BW);
  localparam int QW = $clog2(MAX_OUTSTANDING);
  localparam int CW = QW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_CMD = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cmd_write;
  logic [AW-1:0]   r_addr;
  logic [BW-1:0]   r_be;
  logic [DW-1:0]   r_wdata;
  logic [2:0]      r_cmd_op;
  logic [OB-1:0]   r_cmd_off;
  logic            r_exc_ld, r_exc_st;
  logic [OB-1:0]   r_q_off [MAX_OUTSTANDING];
  logic [2:0]      r_q_op  [MAX_OUTSTANDING];
  logic [QW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [OB-1:0]   w_off;
  logic            w_misaligned;
  logic [BW-1:0]   w_be;
  logic [DW-1:0]   w_wdata;
  logic            w_cmd_read, w_push, w_pop, w_accept, w_start;
  logic [CW:0]     w_outstanding;
  logic [OB-1:0]   w_head_off;
  logic [2:0]      w_head_op;
  logic [DW-1:0]   w_lane, w_mask, w_ext;
  logic            w_sign;

  assign w_off = lsu_req_address[OB-1:0];

  // Alignment check and byte-lane enables of the incoming request.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = '1;
    case (lsu_req_opcode[1:0])
      2'b00: w_be = BW'(1) << w_off;
      2'b01: begin
        w_be         = BW'(3) << w_off;
        w_misaligned = w_off[0];
      end
      2'b10: begin
        w_be         = BW'(4'hF) << w_off;
        w_misaligned = (w_off[1:0] != 2'b00);
      end
      default: begin
        w_be         = '1;
        w_misaligned = (DW == 32) || (w_off != '0);
      end
    endcase
  end

`ifdef LSU_STORE_ALIGN_EN
  // Replicate the low access-size bits of store data across all lanes.
  always_comb begin
    w_wdata = lsu_req_writedata;
    case (lsu_req_opcode[1:0])
      2'b00:   w_wdata = {(DW/8){lsu_req_writedata[7:0]}};
      2'b01:   w_wdata = {(DW/16){lsu_req_writedata[15:0]}};
      2'b10:   w_wdata = {(DW/32){lsu_req_writedata[31:0]}};
      default: w_wdata = lsu_req_writedata;
    endcase
  end
`else
  assign w_wdata = lsu_req_writedata;
`endif

  // A read still in the command stage counts as outstanding; a pop this
  // cycle frees a slot immediately so ready can rise in the same cycle.
  assign w_cmd_read    = (r_state == S_CMD) && !r_cmd_write;
  assign w_push        = w_cmd_read && !dbus_waitrequest;
  assign w_pop         = dbus_readdatavalid && (r_count != '0);
  assign w_outstanding = {1'b0, r_count} + (CW+1)'(w_cmd_read) - (CW+1)'(w_pop);
  assign lsu_req_ready = ((r_state == S_IDLE) || !dbus_waitrequest) &&
                         (w_outstanding < (CW+1)'(MAX_OUTSTANDING));
  assign w_accept      = lsu_req_valid && lsu_req_ready;
  assign w_start       = w_accept && !w_misaligned;

  // Command-stage next state: a new aligned accept always lands in CMD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_CMD;
      S_CMD:   if (!dbus_waitrequest) w_state_nxt = w_start ? S_CMD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, command stage and exception pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cmd_write <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_cmd_op    <= '0;
      r_cmd_off   <= '0;
      r_exc_ld    <= 1'b0;
      r_exc_st    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_exc_ld <= w_accept && w_misaligned && !lsu_req_write;
      r_exc_st <= w_accept && w_misaligned &&  lsu_req_write;
      if (w_start) begin
        r_cmd_write <= lsu_req_write;
        r_addr      <= {lsu_req_address[AW-1:OB], {OB{1'b0}}};
        r_be        <= w_be;
        r_wdata     <= w_wdata;
        r_cmd_op    <= lsu_req_opcode;
        r_cmd_off   <= w_off;
      end
    end
  end

  // Load metadata queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + QW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + QW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_off[r_wr_ptr] <= r_cmd_off;
      r_q_op[r_wr_ptr]  <= r_cmd_op;
    end
  end

  assign w_head_off = r_q_off[r_rd_ptr];
  assign w_head_op  = r_q_op[r_rd_ptr];
  assign w_lane     = dbus_readdata >> {w_head_off, 3'b000};

  // Truncate the selected lane to the access size and extend to DW.
  always_comb begin
    w_mask = '1;
    w_sign = w_lane[DW-1];
    case (w_head_op[1:0])
      2'b00: begin w_mask = DW'(8'hFF);         w_sign = w_lane[7];  end
      2'b01: begin w_mask = DW'(16'hFFFF);      w_sign = w_lane[15]; end
      2'b10: begin w_mask = DW'(32'hFFFF_FFFF); w_sign = w_lane[31]; end
      default: begin w_mask = '1;               w_sign = w_lane[DW-1]; end
    endcase
    w_ext = (w_lane & w_mask) | ((w_sign && !w_head_op[2]) ? ~w_mask : '0);
  end

  assign lsu_resp_valid                  = w_pop;
  assign lsu_resp_readdata               = w_pop ? w_ext : '0;
  assign dbus_read                       = w_cmd_read;
  assign dbus_write                      = (r_state == S_CMD) && r_cmd_write;
  assign dbus_address                    = r_addr;
  assign dbus_byte_enable                = r_be;
  assign dbus_writedata                  = r_wdata;
  assign exception_load_addr_misaligned  = r_exc_ld;
  assign exception_store_addr_misaligned = r_exc_st;
  assign lsu_busy                        = (r_state == S_CMD) || (r_count != '0);
  assign dbg_state                       = r_state;
endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: directed checks of lsu_pipe with a 32-bit and a 64-bit instance.
module tb_lsu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // 32-bit instance signals
  logic        a_valid, a_ready, a_write;
  logic [2:0]  a_op;
  logic [31:0] a_addr, a_wd;
  logic        a_rd, a_wr;
  logic [31:0] a_baddr;
  logic [3:0]  a_be;
  logic [31:0] a_bwd;
  logic        a_wait;
  logic [31:0] a_rdata;
  logic        a_rvalid, a_resp_v;
  logic [31:0] a_resp;
  logic        a_exl, a_exs, a_busy, a_dbg;

  // 64-bit instance signals
  logic        b_valid, b_ready, b_write;
  logic [2:0]  b_op;
  logic [31:0] b_addr;
  logic [63:0] b_wd;
  logic        b_rd, b_wr;
  logic [31:0] b_baddr;
  logic [7:0]  b_be;
  logic [63:0] b_bwd;
  logic        b_wait;
  logic [63:0] b_rdata;
  logic        b_rvalid, b_resp_v;
  logic [63:0] b_resp;
  logic        b_exl, b_exs, b_busy, b_dbg;

  lsu_pipe #(.DW(32), .AW(32), .MAX_OUTSTANDING(4)) u_dut32 (
    .clk(clk), .rst(rst),
    .lsu_req_valid(a_valid), .lsu_req_ready(a_ready), .lsu_req_write(a_write),
    .lsu_req_opcode(a_op), .lsu_req_address(a_addr), .lsu_req_writedata(a_wd),
    .dbus_read(a_rd), .dbus_write(a_wr), .dbus_address(a_baddr),
    .dbus_byte_enable(a_be), .dbus_writedata(a_bwd), .dbus_waitrequest(a_wait),
    .dbus_readdata(a_rdata), .dbus_readdatavalid(a_rvalid),
    .lsu_resp_valid(a_resp_v), .lsu_resp_readdata(a_resp),
    .exception_load_addr_misaligned(a_exl), .exception_store_addr_misaligned(a_exs),
    .lsu_busy(a_busy), .dbg_state(a_dbg)
  );

  lsu_pipe #(.DW(64), .AW(32), .MAX_OUTSTANDING(4)) u_dut64 (
    .clk(clk), .rst(rst),
    .lsu_req_valid(b_valid), .lsu_req_ready(b_ready), .lsu_req_write(b_write),
    .lsu_req_opcode(b_op), .lsu_req_address(b_addr), .lsu_req_writedata(b_wd),
    .dbus_read(b_rd), .dbus_write(b_wr), .dbus_address(b_baddr),
    .dbus_byte_enable(b_be), .dbus_writedata(b_bwd), .dbus_waitrequest(b_wait),
    .dbus_readdata(b_rdata), .dbus_readdatavalid(b_rvalid),
    .lsu_resp_valid(b_resp_v), .lsu_resp_readdata(b_resp),
    .exception_load_addr_misaligned(b_exl), .exception_store_addr_misaligned(b_exs),
    .lsu_busy(b_busy), .dbg_state(b_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to the sampling point of the next cycle (inputs driven there).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic a_clear();
    a_valid = 0; a_write = 0; a_op = 0; a_addr = 0; a_wd = 0;
    a_wait = 0; a_rdata = 0; a_rvalid = 0;
  endtask

  task automatic b_clear();
    b_valid = 0; b_write = 0; b_op = 0; b_addr = 0; b_wd = 0;
    b_wait = 0; b_rdata = 0; b_rvalid = 0;
  endtask

  // Single load on the 32-bit instance with zero-wait slave.
  task automatic a_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_resp);
    next_cycle();
    a_valid = 1; a_write = 0; a_op = op; a_addr = addr;
    settle();
    check_val({tag, "_ready"}, a_ready, 1);
    next_cycle();
    a_valid = 0;
    settle();
    check_val({tag, "_read"}, a_rd, 1);
    check_val({tag, "_addr"}, a_baddr, {addr[31:2], 2'b00});
    check_val({tag, "_be"}, a_be, exp_be);
    next_cycle();
    a_rvalid = 1; a_rdata = rdata;
    settle();
    check_val({tag, "_rvalid"}, a_resp_v, 1);
    check_val({tag, "_resp"}, a_resp, exp_resp);
    next_cycle();
    a_rvalid = 0;
  endtask

  initial begin
    a_clear();
    b_clear();
    repeat (3) next_cycle();
    settle();
    // Reset state
    check_val("rst_ready", a_ready, 1);
    check_val("rst_read", a_rd, 0);
    check_val("rst_write", a_wr, 0);
    check_val("rst_be", a_be, 0);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_state", a_dbg, 0);
    check_val("rst_resp_v", a_resp_v, 0);
    rst = 1;

    // LB / LBU at 0x1003
    a_load("lb",  3'b000, 32'h1003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    a_load("lbu", 3'b100, 32'h1003, 32'h80FF_1234, 4'b1000, 32'h0000_0080);
    a_load("lh",  3'b001, 32'h1002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
    a_load("lhu", 3'b101, 32'h1000, 32'h80FF_9234, 4'b0011, 32'h0000_9234);

    // SW with 3 cycles of waitrequest
    next_cycle();
    a_valid = 1; a_write = 1; a_op = 3'b010; a_addr = 32'h2000; a_wd = 32'hDEAD_BEEF;
    settle();
    check_val("sw_ready", a_ready, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      a_valid = 0; a_write = 0; a_wait = (i < 3);
      settle();
      check_val("sw_write", a_wr, 1);
      check_val("sw_addr", a_baddr, 32'h2000);
      check_val("sw_be", a_be, 4'hF);
      check_val("sw_data", a_bwd, 32'hDEAD_BEEF);
      check_val("sw_ready_stall", a_ready, (i < 3) ? 1'b0 : 1'b1);
    end
    next_cycle();
    a_wait = 0;
    settle();
    check_val("sw_done", a_wr, 0);
    check_val("sw_busy", a_busy, 0);

    // Outstanding limit: 5 loads, data withheld
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      a_valid = 1; a_write = 0; a_op = 3'b010; a_addr = 32'h100 + 32'(4*i);
      settle();
      check_val("ob_ready", a_ready, (i < 4) ? 1'b1 : 1'b0);
    end
    next_cycle();
    settle();
    check_val("ob_full_ready", a_ready, 0);
    check_val("ob_full_busy", a_busy, 1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      a_rvalid = 1; a_rdata = 32'h1111_0000 + 32'(i);
      settle();
      if (i == 0) check_val("ob_reraise", a_ready, 1);
      check_val("ob_resp_v", a_resp_v, 1);
      check_val("ob_resp", a_resp, 32'h1111_0000 + 32'(i));
      if (i == 0) begin
        next_cycle();
        a_valid = 0;
        a_rdata = 32'h1111_0001;
        settle();
        check_val("ob_l4_read", a_rd, 1);
        check_val("ob_l4_addr", a_baddr, 32'h110);
        check_val("ob_resp", a_resp, 32'h1111_0001);
        i = 1;
      end
    end
    next_cycle();
    a_rvalid = 0;
    settle();
    check_val("ob_drained", a_busy, 0);

    // Spurious read data with empty queue
    next_cycle();
    a_rvalid = 1; a_rdata = 32'h5555_5555;
    settle();
    check_val("spur_resp_v", a_resp_v, 0);
    next_cycle();
    a_rvalid = 0;
    settle();
    check_val("spur_busy", a_busy, 0);

    // Misaligned LH at 0x1
    next_cycle();
    a_valid = 1; a_write = 0; a_op = 3'b001; a_addr = 32'h1;
    settle();
    check_val("mlh_ready", a_ready, 1);
    next_cycle();
    a_valid = 0;
    settle();
    check_val("mlh_read", a_rd, 0);
    check_val("mlh_exl", a_exl, 1);
    check_val("mlh_exs", a_exs, 0);
    next_cycle();
    settle();
    check_val("mlh_exl_end", a_exl, 0);
    check_val("mlh_busy", a_busy, 0);

    // Misaligned SW at 0x2
    next_cycle();
    a_valid = 1; a_write = 1; a_op = 3'b010; a_addr = 32'h2;
    next_cycle();
    a_valid = 0; a_write = 0;
    settle();
    check_val("msw_write", a_wr, 0);
    check_val("msw_exs", a_exs, 1);
    check_val("msw_exl", a_exl, 0);

    // SB at 0x2 with 0xA5
    next_cycle();
    a_valid = 1; a_write = 1; a_op = 3'b000; a_addr = 32'h2; a_wd = 32'h0000_00A5;
    next_cycle();
    a_valid = 0; a_write = 0;
    settle();
    check_val("sb_write", a_wr, 1);
    check_val("sb_be", a_be, 4'b0100);
`ifdef LSU_STORE_ALIGN_EN
    check_val("sb_data", a_bwd, 32'hA5A5_A5A5);
`else
    check_val("sb_data", a_bwd, 32'h0000_00A5);
`endif

    // 64-bit LD at 0x8 and LW at 0xC
    next_cycle();
    b_valid = 1; b_op = 3'b011; b_addr = 32'h8;
    next_cycle();
    b_valid = 0;
    settle();
    check_val("ld_read", b_rd, 1);
    check_val("ld_be", b_be, 8'hFF);
    check_val("ld_addr", b_baddr, 32'h8);
    next_cycle();
    b_rvalid = 1; b_rdata = 64'h0123_4567_89AB_CDEF;
    settle();
    check_val("ld_resp", b_resp, 64'h0123_4567_89AB_CDEF);
    next_cycle();
    b_rvalid = 0;
    b_valid = 1; b_op = 3'b010; b_addr = 32'hC;
    next_cycle();
    b_valid = 0;
    settle();
    check_val("lw64_be", b_be, 8'hF0);
    check_val("lw64_addr", b_baddr, 32'h8);
    next_cycle();
    b_rvalid = 1;
    settle();
    check_val("lw64_resp", b_resp, 64'h0000_0000_0123_4567);
    next_cycle();
    b_rvalid = 0;

    // Reset mid-operation: issued load, then reset, then late data
    next_cycle();
    a_valid = 1; a_write = 0; a_op = 3'b010; a_addr = 32'h40;
    next_cycle();
    a_valid = 0;
    settle();
    check_val("mid_read", a_rd, 1);
    #1 rst = 0;
    #1;
    check_val("mid_rst_read", a_rd, 0);
    check_val("mid_rst_busy", a_busy, 0);
    next_cycle();
    rst = 1;
    next_cycle();
    a_rvalid = 1; a_rdata = 32'h7777_7777;
    settle();
    check_val("mid_late_resp", a_resp_v, 0);
    next_cycle();
    a_rvalid = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
